// File: rtl/axis_src_arbiter.sv
// Round-robin arbiter feeding one AXIS C2H packetizer from NUM_SRC record sources,
// with a per-packet watchdog that recovers a stalled packetizer through its rst_en input.
module axis_src_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned DATA_WIDTH  = 4064,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                           m_axis_c2h_aclk,
    input  logic                           m_axis_c2h_aresetn,
    input  logic [NUM_SRC-1:0]             src_en,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    output logic [NUM_SRC-1:0]             src_ack,
    output logic                           pk_data_valid,
    output logic [DATA_WIDTH-1:0]          pk_data,
    input  logic                           pk_data_next,
    output logic                           pk_rst_en,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy,
    output logic [NUM_SRC*16-1:0]          pkt_cnt,
    output logic                           timeout_err,
    input  logic                           err_clr
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDOG_W-1:0]   WDOG_MAX   = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_WIDTH-1:0] LAST_RESET = ID_WIDTH'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOffer,
        StDrain,
        StRecover
    } state_e;

    state_e                       r_state,         w_state;
    logic                         r_pk_data_valid, w_pk_data_valid;
    logic [DATA_WIDTH-1:0]        r_pk_data,       w_pk_data;
    logic [NUM_SRC-1:0]           r_src_ack,       w_src_ack;
    logic                         r_pk_rst_en,     w_pk_rst_en;
    logic [ID_WIDTH-1:0]          r_grant_id,      w_grant_id;
    logic                         r_busy,          w_busy;
    logic [NUM_SRC*16-1:0]        r_pkt_cnt,       w_pkt_cnt;
    logic                         r_timeout_err,   w_timeout_err;
    logic [ID_WIDTH-1:0]          r_last_grant,    w_last_grant;
    logic [WDOG_W-1:0]            r_wdog,          w_wdog;
    logic                         r_rec_cnt,       w_rec_cnt;

    logic [NUM_SRC-1:0]           w_elig;
    logic                         w_found;
    logic [ID_WIDTH-1:0]          w_winner;
    logic [ID_WIDTH:0]            w_cand;
    logic                         w_timeout;

    assign w_elig = src_valid & src_en;

    // Walk last_grant+1 .. last_grant+NUM_SRC (mod NUM_SRC); first eligible wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            w_cand = {1'b0, r_last_grant} + (ID_WIDTH + 1)'(k);
            if (w_cand >= (ID_WIDTH + 1)'(NUM_SRC)) begin
                w_cand = w_cand - (ID_WIDTH + 1)'(NUM_SRC);
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!w_found && w_elig[i] && (w_cand == (ID_WIDTH + 1)'(i))) begin
                    w_found  = 1'b1;
                    w_winner = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        w_state         = r_state;
        w_pk_data_valid = r_pk_data_valid;
        w_pk_data       = r_pk_data;
        w_src_ack       = '0;
        w_pk_rst_en     = r_pk_rst_en;
        w_grant_id      = r_grant_id;
        w_pkt_cnt       = r_pkt_cnt;
        w_last_grant    = r_last_grant;
        w_wdog          = r_wdog;
        w_rec_cnt       = r_rec_cnt;
        w_timeout       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!r_pk_data_valid && pk_data_next && w_found) begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (w_winner == ID_WIDTH'(i)) begin
                            w_pk_data    = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                            w_src_ack[i] = 1'b1;
                        end
                    end
                    w_pk_data_valid = 1'b1;
                    w_grant_id      = w_winner;
                    w_wdog          = '0;
                    w_state         = StOffer;
                end
            end
            StOffer: begin
                w_wdog = r_wdog + 1'b1;
                if (!pk_data_next) begin
                    w_pk_data_valid = 1'b0;
                    w_wdog          = '0;
                    w_state         = StDrain;
                end else if (r_wdog == WDOG_MAX) begin
                    w_timeout = 1'b1;
                end
            end
            StDrain: begin
                w_wdog = r_wdog + 1'b1;
                if (pk_data_next) begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (r_grant_id == ID_WIDTH'(i)) begin
                            w_pkt_cnt[i*16 +: 16] = r_pkt_cnt[i*16 +: 16] + 16'd1;
                        end
                    end
                    w_last_grant = r_grant_id;
                    w_state      = StIdle;
                end else if (r_wdog == WDOG_MAX) begin
                    w_timeout = 1'b1;
                end
            end
            StRecover: begin
                // Packetizer reset is held low for exactly two cycles.
                if (r_rec_cnt) begin
                    w_pk_rst_en = 1'b1;
                    w_rec_cnt   = 1'b0;
                    w_state     = StIdle;
                end else begin
                    w_rec_cnt = 1'b1;
                end
            end
            default: w_state = StIdle;
        endcase

        if (w_timeout) begin
            w_pk_data_valid = 1'b0;
            w_pk_rst_en     = 1'b0;
            w_last_grant    = r_grant_id;
            w_rec_cnt       = 1'b0;
            w_state         = StRecover;
        end

        // A timeout on the same edge as err_clr keeps the flag set.
        w_timeout_err = w_timeout | (r_timeout_err & ~err_clr);
        w_busy        = (w_state != StIdle);
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            r_state         <= StIdle;
            r_pk_data_valid <= 1'b0;
            r_pk_data       <= '0;
            r_src_ack       <= '0;
            r_pk_rst_en     <= 1'b1;
            r_grant_id      <= '0;
            r_busy          <= 1'b0;
            r_pkt_cnt       <= '0;
            r_timeout_err   <= 1'b0;
            r_last_grant    <= LAST_RESET;
            r_wdog          <= '0;
            r_rec_cnt       <= 1'b0;
        end else begin
            r_state         <= w_state;
            r_pk_data_valid <= w_pk_data_valid;
            r_pk_data       <= w_pk_data;
            r_src_ack       <= w_src_ack;
            r_pk_rst_en     <= w_pk_rst_en;
            r_grant_id      <= w_grant_id;
            r_busy          <= w_busy;
            r_pkt_cnt       <= w_pkt_cnt;
            r_timeout_err   <= w_timeout_err;
            r_last_grant    <= w_last_grant;
            r_wdog          <= w_wdog;
            r_rec_cnt       <= w_rec_cnt;
        end
    end

    assign src_ack       = r_src_ack;
    assign pk_data_valid = r_pk_data_valid;
    assign pk_data       = r_pk_data;
    assign pk_rst_en     = r_pk_rst_en;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;
    assign pkt_cnt       = r_pkt_cnt;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_axis_src_arbiter.sv
// Directed bench for axis_src_arbiter with a small packetizer model that can be made to stall.
module tb_axis_src_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NS-1:0]   src_en = '1;
    logic [NS-1:0]   src_valid = '0;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_ack;
    logic            pk_data_valid;
    logic [DW-1:0]   pk_data;
    logic            pk_data_next;
    logic            pk_rst_en;
    logic [1:0]      grant_id;
    logic            busy;
    logic [NS*16-1:0] pkt_cnt;
    logic            timeout_err;
    logic            err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    bit stuck = 1'b0;
    int pk_cnt_m;
    logic [NS-1:0] ack_q[$];
    logic [DW-1:0] data_q[$];

    localparam logic [DW-1:0] W0 = 32'hA0A0_0000;
    localparam logic [DW-1:0] W1 = 32'hB1B1_0001;
    localparam logic [DW-1:0] W2 = 32'hC2C2_0002;
    localparam logic [DW-1:0] W3 = 32'hD3D3_0003;

    assign src_data = {W3, W2, W1, W0};

    always #5 clk = ~clk;

    axis_src_arbiter #(
        .NUM_SRC     (NS),
        .DATA_WIDTH  (DW),
        .ID_WIDTH    (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .m_axis_c2h_aclk    (clk),
        .m_axis_c2h_aresetn (rstn),
        .src_en             (src_en),
        .src_valid          (src_valid),
        .src_data           (src_data),
        .src_ack            (src_ack),
        .pk_data_valid      (pk_data_valid),
        .pk_data            (pk_data),
        .pk_data_next       (pk_data_next),
        .pk_rst_en          (pk_rst_en),
        .grant_id           (grant_id),
        .busy               (busy),
        .pkt_cnt            (pkt_cnt),
        .timeout_err        (timeout_err),
        .err_clr            (err_clr)
    );

    // Packetizer model: accepts when idle, then holds data_next low for 9 cycles (or forever if stuck).
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pk_data_next <= 1'b1;
            pk_cnt_m     <= 0;
        end else if (!pk_rst_en) begin
            pk_data_next <= 1'b1;
            pk_cnt_m     <= 0;
        end else if (pk_data_next && pk_data_valid) begin
            pk_data_next <= 1'b0;
            pk_cnt_m     <= 8;
        end else if (!pk_data_next && !stuck) begin
            if (pk_cnt_m == 0) pk_data_next <= 1'b1;
            else pk_cnt_m <= pk_cnt_m - 1;
        end
    end

    // Log every ack cycle together with the record offered on it.
    always begin
        @(posedge clk);
        #1;
        if (rstn && src_ack != '0) begin
            ack_q.push_back(src_ack);
            data_q.push_back(pk_data);
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        src_valid = '0;
        src_en = '1;
        err_clr = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        ack_q.delete();
        data_q.delete();
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        int c = 0;
        while (ack_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (ack_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        src_valid = '0;
        @(negedge clk);
        checks++; if (pk_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pk_data_valid); end
        checks++; if (pk_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", pk_data); end
        checks++; if (src_ack !== '0) begin errors++; $display("FAIL rst_ack: got %b want 0", src_ack); end
        checks++; if (pk_rst_en !== 1'b1) begin errors++; $display("FAIL rst_rst_en: got %b want 1", pk_rst_en); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL rst_pkt_cnt: got %h want 0", pkt_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", timeout_err); end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        src_valid = 4'b0100;
        wait_acks(1, 50, ok);
        src_valid = '0;
        checks++; if (!ok) begin errors++; $display("FAIL single_ack_wait: got %0d acks want 1", ack_q.size()); end
        checks++; if (busy !== 1'b1 || pk_data_valid !== 1'b1) begin errors++; $display("FAIL single_offer: got busy=%b valid=%b want 1 1", busy, pk_data_valid); end
        wait_idle(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle_wait: got busy=%b want 0", busy); end
        repeat (3) @(negedge clk);
        checks++; if (ack_q.size() !== 1) begin errors++; $display("FAIL single_ack_count: got %0d want 1", ack_q.size()); end
        if (ack_q.size() > 0) begin
            checks++; if (ack_q[0] !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack_q[0]); end
            checks++; if (data_q[0] !== W2) begin errors++; $display("FAIL single_data: got %h want %h", data_q[0], W2); end
        end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        checks++; if (pkt_cnt !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL single_pkt_cnt: got %h want 0000000100000000", pkt_cnt); end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [NS-1:0] exp_seq [6];
        logic [DW-1:0] exp_dat [6];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_dat = '{W0, W1, W2, W3, W0, W1};
        do_reset();
        src_valid = 4'b1111;
        wait_acks(6, 200, ok);
        src_valid = '0;
        checks++; if (!ok) begin errors++; $display("FAIL rr_ack_wait: got %0d acks want 6", ack_q.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < ack_q.size()) begin
                checks++; if (ack_q[k] !== exp_seq[k]) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", k, ack_q[k], exp_seq[k]); end
                checks++; if (data_q[k] !== exp_dat[k]) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, data_q[k], exp_dat[k]); end
            end
        end
        wait_idle(60, ok);
        @(negedge clk);
        checks++; if (pkt_cnt !== 64'h0001_0001_0002_0002) begin errors++; $display("FAIL rr_pkt_cnt: got %h want 0001000100020002", pkt_cnt); end
    endtask

    task automatic test_masking();
        bit ok;
        logic [NS-1:0] exp_seq [4];
        logic [NS-1:0] seen;
        exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        do_reset();
        src_en = 4'b1010;
        src_valid = 4'b1111;
        wait_acks(4, 150, ok);
        src_valid = '0;
        checks++; if (!ok) begin errors++; $display("FAIL mask_ack_wait: got %0d acks want 4", ack_q.size()); end
        seen = '0;
        for (int k = 0; k < ack_q.size(); k++) begin
            seen = seen | ack_q[k];
            if (k < 4) begin
                checks++; if (ack_q[k] !== exp_seq[k]) begin errors++; $display("FAIL mask_ack%0d: got %b want %b", k, ack_q[k], exp_seq[k]); end
            end
        end
        checks++; if ((seen & 4'b0101) !== 4'b0000) begin errors++; $display("FAIL mask_never: got %b want 0000 on masked bits", seen & 4'b0101); end
        wait_idle(60, ok);
        src_en = '1;
    endtask

    task automatic test_watchdog();
        bit ok;
        int n;
        do_reset();
        stuck = 1'b1;
        src_valid = 4'b0001;
        wait_acks(1, 50, ok);
        src_valid = '0;
        checks++; if (!ok) begin errors++; $display("FAIL wd_ack_wait: got %0d acks want 1", ack_q.size()); end
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        // 2 OFFER cycles, then wdog counts 0..15 in DRAIN.
        checks++; if (n !== 18) begin errors++; $display("FAIL wd_latency: got %0d cycles want 18", n); end
        checks++; if (pk_rst_en !== 1'b0) begin errors++; $display("FAIL wd_rst_en0: got %b want 0", pk_rst_en); end
        checks++; if (busy !== 1'b1 || pk_data_valid !== 1'b0) begin errors++; $display("FAIL wd_recover: got busy=%b valid=%b want 1 0", busy, pk_data_valid); end
        checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL wd_pkt_cnt: got %h want 0", pkt_cnt); end
        @(negedge clk);
        checks++; if (pk_rst_en !== 1'b0) begin errors++; $display("FAIL wd_rst_en1: got %b want 0", pk_rst_en); end
        @(negedge clk);
        checks++; if (pk_rst_en !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_release: got rst_en=%b busy=%b want 1 0", pk_rst_en, busy); end
        stuck = 1'b0;
        ack_q.delete();
        data_q.delete();
        src_valid = 4'b0011;
        wait_acks(1, 50, ok);
        src_valid = '0;
        checks++; if (!ok || ack_q[0] !== 4'b0010) begin errors++; $display("FAIL wd_next_grant: got %b want 0010", ok ? ack_q[0] : 4'bxxxx); end
        wait_idle(60, ok);
        @(negedge clk);
        checks++; if (pkt_cnt !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL wd_pkt_after: got %h want 0000000000010000", pkt_cnt); end
    endtask

    task automatic test_err_clr();
        bit ok;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL clr_pre: got %b want 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL clr_clear: got %b want 0", timeout_err); end
        stuck = 1'b1;
        ack_q.delete();
        data_q.delete();
        src_valid = 4'b0100;
        wait_acks(1, 50, ok);
        src_valid = '0;
        checks++; if (!ok || ack_q[0] !== 4'b0100) begin errors++; $display("FAIL clr_grant: got %0d acks want source 2", ack_q.size()); end
        repeat (17) @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL clr_before: got %b want 0", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL clr_collide: got %b want 1", timeout_err); end
        checks++; if (pk_rst_en !== 1'b0) begin errors++; $display("FAIL clr_rst_en: got %b want 0", pk_rst_en); end
        stuck = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok || timeout_err !== 1'b1) begin errors++; $display("FAIL clr_sticky: got busy=%b err=%b want 0 1", busy, timeout_err); end
        checks++; if (pkt_cnt !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL clr_pkt_cnt: got %h want 0000000000010000", pkt_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        do_reset();
        src_valid = 4'b0010;
        wait_acks(1, 50, ok);
        src_valid = '0;
        wait_idle(60, ok);
        checks++; if (pkt_cnt !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL mid_pre_cnt: got %h want 0000000000010000", pkt_cnt); end
        ack_q.delete();
        data_q.delete();
        src_valid = 4'b1000;
        wait_acks(1, 50, ok);
        src_valid = '0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1 || grant_id !== 2'd3 || pk_data_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: got busy=%b grant=%0d valid=%b want 1 3 0", busy, grant_id, pk_data_valid); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: got %0d want 0", grant_id); end
        checks++; if (pk_data !== '0 || pk_data_valid !== 1'b0) begin errors++; $display("FAIL mid_data: got %h/%b want 0/0", pk_data, pk_data_valid); end
        checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL mid_pkt_cnt: got %h want 0", pkt_cnt); end
        checks++; if (pk_rst_en !== 1'b1 || src_ack !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_misc: got rst_en=%b ack=%b err=%b want 1 0000 0", pk_rst_en, src_ack, timeout_err); end
        @(negedge clk);
        rstn = 1'b1;
        ack_q.delete();
        data_q.delete();
        src_valid = 4'b0011;
        wait_acks(1, 50, ok);
        src_valid = '0;
        checks++; if (!ok || ack_q[0] !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %0d acks want source 0", ack_q.size()); end
        checks++; if (data_q.size() == 0 || data_q[0] !== W0) begin errors++; $display("FAIL mid_first_data: got %0d records want %h", data_q.size(), W0); end
        wait_idle(60, ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_watchdog();
        test_err_clr();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
